// File: rtl/fuel_meter.sv
// rtl/fuel_meter.sv - fuel pump meter: times the pump, counts liters, reports a saturating cost
// Optional early-abort input `stop` is built only when FUEL_STOP_EN is defined.
module fuel_meter #(
  parameter int unsigned TICKS_PER_LITER = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] fuel_type,
  input  logic [3:0] liters_req,
  input  logic       disp_done,
`ifdef FUEL_STOP_EN
  input  logic       stop,
`endif
  output logic       pump_on,
  output logic [3:0] liters_out,
  output logic [7:0] final_cost,
  output logic       start,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DISPENSE, REPORT, WAIT_DONE} state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_LITER - 1);
  localparam logic [7:0] COST_MAX  = 8'd99;

  state_t      state_q;
  logic [7:0]  tick_q;
  logic [3:0]  liters_q;
  logic [3:0]  lreq_q;
  logic [2:0]  price_q;
  logic [6:0]  acc_q;
  logic [7:0]  final_cost_q;
  logic        pump_on_q;
  logic        start_q;
  logic        busy_q;

  logic        stop_w;
  logic        liter_done;
  logic [3:0]  liters_d;
  logic [7:0]  sum_w;
  logic [6:0]  acc_d;

`ifdef FUEL_STOP_EN
  assign stop_w = stop;
`else
  assign stop_w = 1'b0;
`endif

  function automatic logic [2:0] price_of(input logic [1:0] grade);
    case (grade)
      2'd0:    price_of = 3'd3;
      2'd1:    price_of = 3'd4;
      2'd2:    price_of = 3'd5;
      default: price_of = 3'd7;
    endcase
  endfunction

  // Accumulator clamps at 99 so the two-digit display never wraps.
  always_comb begin
    liter_done = (tick_q == TICK_LAST);
    liters_d   = liters_q + 4'd1;
    sum_w      = {1'b0, acc_q} + {5'd0, price_q};
    acc_d      = (sum_w > COST_MAX) ? COST_MAX[6:0] : sum_w[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      liters_q     <= '0;
      lreq_q       <= '0;
      price_q      <= '0;
      acc_q        <= '0;
      final_cost_q <= '0;
      pump_on_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && (liters_req != 4'd0)) begin
            lreq_q    <= liters_req;
            price_q   <= price_of(fuel_type);
            liters_q  <= '0;
            acc_q     <= '0;
            tick_q    <= '0;
            pump_on_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (liter_done) begin
            tick_q   <= '0;
            liters_q <= liters_d;
            acc_q    <= acc_d;
          end else begin
            tick_q <= tick_q + 8'd1;
          end
          // A stop landing on a completion tick still charges that liter.
          if ((liter_done && (liters_d == lreq_q)) || stop_w) begin
            final_cost_q <= {1'b0, (liter_done ? acc_d : acc_q)};
            tick_q       <= '0;
            pump_on_q    <= 1'b0;
            start_q      <= 1'b1;
            state_q      <= REPORT;
          end
        end
        REPORT: begin
          start_q <= 1'b0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (disp_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pump_on    = pump_on_q;
  assign liters_out = liters_q;
  assign final_cost = final_cost_q;
  assign start      = start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fuel_meter.sv
// tb/tb_fuel_meter.sv - scoreboard bench for fuel_meter (TICKS_PER_LITER = 4)
module tb_fuel_meter;
  localparam int TPL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [1:0] fuel_type;
  logic [3:0] liters_req;
  logic       disp_done;
  logic       stop;
  logic       pump_on;
  logic [3:0] liters_out;
  logic [7:0] final_cost;
  logic       start;
  logic       busy;

  fuel_meter #(.TICKS_PER_LITER(TPL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .fuel_type  (fuel_type),
    .liters_req (liters_req),
    .disp_done  (disp_done),
`ifdef FUEL_STOP_EN
    .stop       (stop),
`endif
    .pump_on    (pump_on),
    .liters_out (liters_out),
    .final_cost (final_cost),
    .start      (start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cost;
    int liters;
    int scyc;
    int pumps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pump_cnt = 0;
  logic prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per start pulse, independent of stimulus.
  always @(negedge clk) begin
    if (prev_start) check("start_one_cycle", start, 0);
    if (reset) begin
      pump_cnt = 0;
    end else begin
      if (pump_on) pump_cnt++;
      if (start && !prev_start) begin
        if (sb.size() == 0) begin
          check("unexpected_start", start, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("final_cost", final_cost, e.cost);
          check("liters_out", liters_out, e.liters);
          check("start_cycle", cyc, e.scyc);
          check("pump_cycles", pump_cnt, e.pumps);
          check("busy_in_report", busy, 1);
        end
        pump_cnt = 0;
      end
    end
    prev_start = start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", start, 1);
  endtask

  // One transaction; stop_at < 0 means no early abort; hold_wait exercises WAIT_DONE.
  task automatic run_txn(input int g, input int l, input int stop_at,
                         input int e_cost, input int e_lit, input int e_pump,
                         input bit hold_wait);
    exp_t e;
    step();
    e.cost = e_cost; e.liters = e_lit; e.scyc = cyc + 1 + e_pump; e.pumps = e_pump;
    sb.push_back(e);
    req = 1'b1; fuel_type = 2'(g); liters_req = 4'(l);
    step();
    req = 1'b0; fuel_type = ~2'(g); liters_req = 4'hF;
    if (stop_at > 0) begin
      repeat (stop_at - 1) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    wait_start();
    step();
    if (hold_wait) begin
      for (int i = 0; i < 10; i++) begin
        req = 1'b1; liters_req = 4'd3;
        step();
        req = 1'b0;
        check("wait_busy", busy, 1);
        check("wait_pump", pump_on, 0);
      end
    end
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("idle_busy", busy, 0);
    check("held_liters", liters_out, e_lit);
    check("held_cost", final_cost, e_cost);
    step();
    check("idle_pump", pump_on, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; fuel_type = 2'd0; liters_req = 4'd0;
    disp_done = 1'b0; stop = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_pump", pump_on, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_liters", liters_out, 0);
    check("rst_cost", final_cost, 0);

    run_txn(2, 5, -1, 25, 5, 20, 1'b0);
    run_txn(3, 15, -1, 99, 15, 60, 1'b1);
    run_txn(0, 1, -1, 3, 1, 4, 1'b0);
    run_txn(1, 3, -1, 12, 3, 12, 1'b0);
    run_txn(3, 14, -1, 98, 14, 56, 1'b0);

    // Zero-liter request is ignored.
    step();
    req = 1'b1; fuel_type = 2'd2; liters_req = 4'd0;
    step();
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 4 == 0) begin
        check("zero_busy", busy, 0);
        check("zero_pump", pump_on, 0);
      end
    end

    // Reset mid-dispense, with a coincident request that must lose to reset.
    req = 1'b1; fuel_type = 2'd1; liters_req = 4'd4;
    step();
    req = 1'b0;
    repeat (6) step();
    check("pre_rst_pump", pump_on, 1);
    check("pre_rst_liters", liters_out, 1);
    reset = 1'b1; req = 1'b1; liters_req = 4'd2; stop = 1'b1; disp_done = 1'b1;
    step();
    reset = 1'b0; req = 1'b0; stop = 1'b0; disp_done = 1'b0;
    check("mid_rst_pump", pump_on, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_liters", liters_out, 0);
    check("mid_rst_cost", final_cost, 0);
    check("mid_rst_start", start, 0);
    run_txn(1, 4, -1, 16, 4, 16, 1'b0);

`ifdef FUEL_STOP_EN
    run_txn(0, 6, 10, 6, 2, 10, 1'b0);
    run_txn(0, 6, 8, 6, 2, 8, 1'b0);
    run_txn(2, 3, 1, 0, 0, 1, 1'b0);
`endif

    repeat (5) step();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fuel_meter.md
FUEL_METER -- requirements
Module: fuel_meter

Interface
REQ-001 SHALL have parameter TICKS_PER_LITER, default 4, clock cycles of pump run per dispensed liter (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 1, dispense request, sampled only in IDLE.
REQ-005 SHALL have port fuel_type, input, 2, grade select (price per liter: 0->3, 1->4, 2->5, 3->7).
REQ-006 SHALL have port liters_req, input, 4, liters to dispense (1..15).
REQ-007 SHALL have port disp_done, input, 1, downstream display finished showing final_cost.
REQ-008 SHALL have port stop, input, 1, early abort (present only with FUEL_STOP_EN).
REQ-009 SHALL have port pump_on, output, 1, pump motor enable.
REQ-010 SHALL have port liters_out, output, 4, liters completed in current/last transaction.
REQ-011 SHALL have port final_cost, output, 8, transaction cost in binary, 0..99.
REQ-012 SHALL have port start, output, 1, one-cycle pulse telling downstream display to begin.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, DISPENSE, REPORT, WAIT_DONE.
REQ-015 IDLE: req=1 with liters_req!=0 SHALL latch fuel_type and liters_req, clear liters_out and cost accumulator, enter DISPENSE next cycle; req with liters_req=0 SHALL be ignored.
REQ-016 req, fuel_type, liters_req changes outside IDLE SHALL be ignored.
REQ-017 pump_on SHALL equal 1 exactly in DISPENSE cycles.
REQ-018 DISPENSE: tick counter SHALL count 0..TICKS_PER_LITER-1; on the cycle it reaches TICKS_PER_LITER-1, liters_out SHALL increment and accumulator SHALL add latched price, counter wrapping to 0.
REQ-019 Accumulator SHALL saturate at 99 (e.g. grade 3 x 15 L = 105 -> 99); no wrap.
REQ-020 Liter completion making liters_out equal latched liters_req SHALL move to REPORT next cycle.
REQ-021 final_cost SHALL load the accumulator on the edge entering REPORT and hold until the next such load or reset.
REQ-022 REPORT SHALL last exactly one cycle with start=1, then enter WAIT_DONE.
REQ-023 WAIT_DONE SHALL hold until disp_done=1, then enter IDLE next cycle; disp_done in other states SHALL be ignored.
REQ-024 Latency: req accepted at cycle 0 -> DISPENSE cycles 1..L*TICKS_PER_LITER, start at cycle L*TICKS_PER_LITER+1.
REQ-025 liters_out SHALL hold its final value through REPORT, WAIT_DONE and IDLE until next accepted req.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, pump_on=0, start=0, busy=0, liters_out=0, final_cost=0, tick counter=0, from any state including mid-DISPENSE.
REQ-027 reset SHALL dominate req, stop and disp_done in the same cycle.

Configuration
REQ-028 Macro FUEL_STOP_EN defined: stop port exists; stop=1 in DISPENSE SHALL enter REPORT next cycle, charging only completed liters (partial liter not charged); stop coincident with a liter completion SHALL charge that liter; stop outside DISPENSE ignored.
REQ-029 Macro FUEL_STOP_EN undefined: stop port absent; dispensing always runs to liters_req.

Verification
REQ-030 Reset, fuel_type=2, liters_req=5, req pulse at cycle 0 -> pump_on cycles 1..20, start pulse cycle 21 only, final_cost=25, liters_out=5.
REQ-031 fuel_type=3, liters_req=15 -> final_cost=99 (saturated), liters_out=15.
REQ-032 In WAIT_DONE hold disp_done=0 for 10 cycles with req pulses -> busy stays 1, no new dispense; disp_done=1 -> IDLE next cycle, busy=0.
REQ-033 req with liters_req=0 -> stays IDLE, pump_on=0, start never asserted.
REQ-034 reset asserted mid-DISPENSE (cycle 7 of fuel_type=1, 4 L) -> next cycle all outputs 0, IDLE; fresh req then behaves as REQ-024.
REQ-035 FUEL_STOP_EN: fuel_type=0, 6 L, stop at cycle 10 -> REPORT at cycle 11, liters_out=2, final_cost=6.
